// File: rtl/ysyx_24100029_clint_if.sv
// Data-bus port between the CPU load/store unit and the CLINT.
// The master issues requests and the CLINT answers as the slave.
interface ysyx_24100029_clint_if;
    logic [31:0] clint_addr;
    logic [1:0]  clint_opcode;
    logic [2:0]  clint_size;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_resp;

    modport master (
        output clint_addr, clint_opcode, clint_size, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_resp
    );

    modport slave (
        input  clint_addr, clint_opcode, clint_size, clint_wdata, clint_wstrb,
        output clint_rdata, clint_resp
    );
endinterface

// File: rtl/ysyx_24100029_clint.sv
// Core-local interruptor: free-running mtime, mtimecmp compare and msip,
// reachable over the data bus with a fixed-latency response.
module ysyx_24100029_clint #(
    parameter int TICK_DIV = 1,
    parameter int RESP_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_24100029_clint_if.slave        bus,
    output logic                        timer_irq,
    output logic                        soft_irq
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [13:0] W_MSIP     = 14'h0000;
    localparam logic [13:0] W_MTCMP_LO = 14'h1000;
    localparam logic [13:0] W_MTCMP_HI = 14'h1001;
    localparam logic [13:0] W_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] W_MTIME_HI = 14'h2FFF;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d, mtime_inc;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [31:0]   hold_q, hold_d;
    logic [31:0]   rd_val;
    logic          timer_irq_q, soft_irq_q;

    logic        tick, accept, is_rd, is_wr, wr_acc;
    logic [13:0] word;
    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.clint_size, bus.clint_addr[31:16], bus.clint_addr[1:0]};

    assign word   = bus.clint_addr[15:2];
    assign is_rd  = (bus.clint_opcode == 2'b01);
    assign is_wr  = (bus.clint_opcode == 2'b10);
    assign accept = (state_q == S_IDLE) && (is_rd || is_wr);
    assign wr_acc = accept && is_wr;

    assign tick      = (presc_q == PRESC_MAX);
    assign presc_d   = tick ? '0 : presc_q + 1'b1;
    assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

    // Written bytes take wdata; the rest follow the (possibly ticked) value,
    // so a tick and a partial mtime write in the same cycle merge cleanly.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mtime_d[8*gi +: 8] =
                (wr_acc && word == W_MTIME_LO && bus.clint_wstrb[gi]) ?
                bus.clint_wdata[8*gi +: 8] : mtime_inc[8*gi +: 8];
            assign mtime_d[32+8*gi +: 8] =
                (wr_acc && word == W_MTIME_HI && bus.clint_wstrb[gi]) ?
                bus.clint_wdata[8*gi +: 8] : mtime_inc[32+8*gi +: 8];
            assign mtimecmp_d[8*gi +: 8] =
                (wr_acc && word == W_MTCMP_LO && bus.clint_wstrb[gi]) ?
                bus.clint_wdata[8*gi +: 8] : mtimecmp_q[8*gi +: 8];
            assign mtimecmp_d[32+8*gi +: 8] =
                (wr_acc && word == W_MTCMP_HI && bus.clint_wstrb[gi]) ?
                bus.clint_wdata[8*gi +: 8] : mtimecmp_q[32+8*gi +: 8];
        end
    endgenerate

    assign msip_d = (wr_acc && word == W_MSIP && bus.clint_wstrb[0]) ?
                    bus.clint_wdata[0] : msip_q;

    always_comb begin
        rd_val = 32'd0;
        case (word)
            W_MSIP:     rd_val = {31'd0, msip_q};
            W_MTCMP_LO: rd_val = mtimecmp_q[31:0];
            W_MTCMP_HI: rd_val = mtimecmp_q[63:32];
            W_MTIME_LO: rd_val = mtime_q[31:0];
            W_MTIME_HI: rd_val = mtime_q[63:32];
            default:    rd_val = 32'd0;
        endcase
    end

    assign hold_d = accept ? (is_rd ? rd_val : 32'd0) : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            hold_q      <= 32'd0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            hold_q      <= hold_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
            soft_irq_q  <= msip_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 3'(RESP_LAT);
                    state_d = (RESP_LAT == 0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q <= 3'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.clint_resp  = (state_q == S_RESP);
        bus.clint_rdata = (state_q == S_RESP) ? hold_q : 32'd0;
    end

    assign timer_irq = timer_irq_q;
    assign soft_irq  = soft_irq_q;

endmodule

// File: tb/tb_ysyx_24100029_clint.sv
// Bench for the CLINT: a register-level reference model for the RESP_LAT=1
// instance, plus two extra instances for latency and reset corner cases.
module tb_ysyx_24100029_clint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: RESP_LAT=1 (modelled), 1: RESP_LAT=0, 2: RESP_LAT=3
    logic        rst_n0, rst_n1, rst_n2;
    logic [1:0]  op_a[3];
    logic [31:0] addr_a[3];
    logic [31:0] wdata_a[3];
    logic [3:0]  wstrb_a[3];
    logic [31:0] rdata_a[3];
    logic        resp_a[3];
    logic        tirq_a[3];
    logic        sirq_a[3];

    ysyx_24100029_clint_if bus0();
    ysyx_24100029_clint_if bus1();
    ysyx_24100029_clint_if bus2();

    assign bus0.clint_opcode = op_a[0];
    assign bus0.clint_addr   = addr_a[0];
    assign bus0.clint_wdata  = wdata_a[0];
    assign bus0.clint_wstrb  = wstrb_a[0];
    assign bus0.clint_size   = 3'd2;
    assign rdata_a[0]        = bus0.clint_rdata;
    assign resp_a[0]         = bus0.clint_resp;

    assign bus1.clint_opcode = op_a[1];
    assign bus1.clint_addr   = addr_a[1];
    assign bus1.clint_wdata  = wdata_a[1];
    assign bus1.clint_wstrb  = wstrb_a[1];
    assign bus1.clint_size   = 3'd2;
    assign rdata_a[1]        = bus1.clint_rdata;
    assign resp_a[1]         = bus1.clint_resp;

    assign bus2.clint_opcode = op_a[2];
    assign bus2.clint_addr   = addr_a[2];
    assign bus2.clint_wdata  = wdata_a[2];
    assign bus2.clint_wstrb  = wstrb_a[2];
    assign bus2.clint_size   = 3'd2;
    assign rdata_a[2]        = bus2.clint_rdata;
    assign resp_a[2]         = bus2.clint_resp;

    ysyx_24100029_clint #(.TICK_DIV(1), .RESP_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(bus0), .timer_irq(tirq_a[0]), .soft_irq(sirq_a[0]));
    ysyx_24100029_clint #(.TICK_DIV(1), .RESP_LAT(0)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(bus1), .timer_irq(tirq_a[1]), .soft_irq(sirq_a[1]));
    ysyx_24100029_clint #(.TICK_DIV(1), .RESP_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n2), .bus(bus2), .timer_irq(tirq_a[2]), .soft_irq(sirq_a[2]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for dut0 ----------------
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_tirq, m_sirq;
    logic [31:0] m_rd;
    logic        tb_acc;

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [63:0] t,
                                           input logic [63:0] c, input logic s);
        case ({a[15:2], 2'b00})
            16'h0000: return {31'd0, s};
            16'h4000: return c[31:0];
            16'h4004: return c[63:32];
            16'hBFF8: return t[31:0];
            16'hBFFC: return t[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    // Apply a byte-enabled write to a 64-bit register mapped at lo_off/lo_off+4.
    function automatic logic [63:0] m_write64(input logic [63:0] cur, input logic [15:0] lo_off,
                                              input logic acc, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] wd,
                                              input logic [3:0] ws);
        logic [63:0] r;
        logic [15:0] off;
        r = cur;
        off = {a[15:2], 2'b00};
        if (acc && op == 2'b10) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b] && off == lo_off)       r[8*b +: 8]      = wd[8*b +: 8];
                if (ws[b] && off == lo_off + 16'd4) r[32 + 8*b +: 8] = wd[8*b +: 8];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n0) begin
        if (!rst_n0) begin
            m_time <= 64'd0;
            m_cmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip <= 1'b0;
            m_tirq <= 1'b0;
            m_sirq <= 1'b0;
            m_rd   <= 32'd0;
        end else begin
            m_tirq <= (m_time >= m_cmp);
            m_sirq <= m_msip;
            m_time <= m_write64(m_time + 64'd1, 16'hBFF8, tb_acc, op_a[0], addr_a[0], wdata_a[0], wstrb_a[0]);
            m_cmp  <= m_write64(m_cmp, 16'h4000, tb_acc, op_a[0], addr_a[0], wdata_a[0], wstrb_a[0]);
            if (tb_acc && op_a[0] == 2'b10 && addr_a[0][15:2] == 14'd0 && wstrb_a[0][0])
                m_msip <= wdata_a[0][0];
            if (tb_acc)
                m_rd <= (op_a[0] == 2'b01) ? m_read(addr_a[0], m_time, m_cmp, m_msip) : 32'd0;
        end
    end

    // Per-cycle monitor of dut0 against the model.
    logic mon_en = 1'b0;
    logic prev_resp0 = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("timer_irq_model", tirq_a[0], m_tirq);
            check("soft_irq_model", sirq_a[0], m_sirq);
            if (!resp_a[0]) check("rdata_idle_zero", rdata_a[0], 0);
            check("resp_single_pulse", prev_resp0 && resp_a[0], 0);
        end
        prev_resp0 <= resp_a[0];
    end

    // One bus transaction; lat = negedges from acceptance edge until resp seen.
    task automatic xact(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int lat);
        @(negedge clk);
        op_a[d] = wr ? 2'b10 : 2'b01;
        addr_a[d] = a;
        wdata_a[d] = wd;
        wstrb_a[d] = ws;
        if (d == 0) tb_acc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_acc = 1'b0;
        lat = 1;
        while (!resp_a[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata_a[d];
        op_a[d] = 2'b00;
        $display("xact dut%0d %s addr=%h wdata=%h wstrb=%b rdata=%h lat=%0d",
                 d, wr ? "WR" : "RD", a, wd, ws, rd, lat);
    endtask

    task automatic do0(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd);
        int lat;
        xact(0, wr, a, wd, ws, rd, lat);
        check("latency_lat1", lat, 2);
        check(wr ? "write_rdata" : "read_model", rd, m_rd);
    endtask

    task automatic spacing(input int d, input int exp_sp);
        int first, second;
        first = -1;
        second = -1;
        @(negedge clk);
        op_a[d] = 2'b01;
        addr_a[d] = 32'h0200_4000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_a[d]) begin
                check("b2b_rdata", rdata_a[d], 32'hFFFF_FFFF);
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        op_a[d] = 2'b00;
        repeat (8) @(negedge clk);
        $display("spacing dut%0d first=%0d second=%0d", d, first, second);
        check("resp_spacing", second - first, exp_sp);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
        logic        exp_soft;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] rd, a;
    int lat;

    initial begin
        vecs[0]  = '{1'b1, 32'h0200_0000, 32'h0000_0001, 4'b0001, 32'h0, 1'b1};
        vecs[1]  = '{1'b0, 32'h0200_0000, 32'h0,         4'b0000, 32'h1, 1'b1};
        vecs[2]  = '{1'b1, 32'h0200_0000, 32'h0,         4'b0000, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0200_0000, 32'h0,         4'b0000, 32'h1, 1'b1};
        vecs[4]  = '{1'b1, 32'h0200_4000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0200_4000, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{1'b1, 32'h0200_4004, 32'h1234_5678, 4'b0101, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0200_4004, 32'h0,         4'b0000, 32'hFF34_FF78, 1'b1};
        vecs[8]  = '{1'b0, 32'h0200_1234, 32'h0,         4'b0000, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0200_8000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 32'h0200_8000, 32'h0,         4'b0000, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h0200_0000, 32'hFFFF_FFFE, 4'b1111, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h0200_0000, 32'h0,         4'b0000, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h0200_4000, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};

        tb_acc = 1'b0;
        for (int d = 0; d < 3; d++) begin
            op_a[d] = 2'b00; addr_a[d] = 32'd0; wdata_a[d] = 32'd0; wstrb_a[d] = 4'd0;
        end
        rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_resp", resp_a[0], 0);
        check("reset_rdata", rdata_a[0], 0);
        check("reset_timer_irq", tirq_a[0], 0);
        check("reset_soft_irq", sirq_a[0], 0);
        rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
        mon_en = 1'b1;

        // Idle 10 cycles, then read mtime lo: 11 ticks precede the acceptance edge.
        repeat (10) @(negedge clk);
        do0(1'b0, 32'h0200_BFF8, 32'd0, 4'd0, rd);
        check("mtime_after_idle", rd, 32'd11);
        check("timer_irq_idle", tirq_a[0], 0);

        for (int i = 0; i < 14; i++) begin
            do0(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_soft_irq", i), sirq_a[0], vecs[i].exp_soft);
        end

        // Timer compare: restart mtime, set mtimecmp = 0x20, wait for the interrupt.
        do0(1'b1, 32'h0200_BFFC, 32'd0, 4'hF, rd);
        do0(1'b1, 32'h0200_BFF8, 32'd0, 4'hF, rd);
        do0(1'b1, 32'h0200_4000, 32'h20, 4'hF, rd);
        do0(1'b1, 32'h0200_4004, 32'd0, 4'hF, rd);
        check("timer_irq_before_cmp", tirq_a[0], 0);
        for (int i = 0; i < 64 && !tirq_a[0]; i++) @(negedge clk);
        check("timer_irq_rises", tirq_a[0], 1);
        do0(1'b1, 32'h0200_4004, 32'd1, 4'hF, rd);
        check("timer_irq_drops", tirq_a[0], 0);

        // Carry from lo into hi, then a lane-1 byte write merged with a tick.
        do0(1'b1, 32'h0200_BFFC, 32'd5, 4'hF, rd);
        do0(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, rd);
        do0(1'b0, 32'h0200_BFFC, 32'd0, 4'd0, rd);
        check("mtime_hi_carry", rd, 32'd6);
        do0(1'b0, 32'h0200_BFF8, 32'd0, 4'd0, rd);
        do0(1'b1, 32'h0200_BFF8, 32'h0000_AB00, 4'b0010, rd);
        do0(1'b0, 32'h0200_BFF8, 32'd0, 4'd0, rd);
        check("mtime_lane1_merge", rd[15:8], 8'hAB);

        // Reserved opcode is ignored.
        @(negedge clk);
        op_a[0] = 2'b11;
        addr_a[0] = 32'h0200_0000;
        repeat (4) begin
            @(negedge clk);
            check("reserved_no_resp", resp_a[0], 0);
        end
        op_a[0] = 2'b00;

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: a = 32'h0200_0000;
                1: a = 32'h0200_4000;
                2: a = 32'h0200_4004;
                3: a = 32'h0200_BFF8;
                4: a = 32'h0200_BFFC;
                default: a = $urandom;
            endcase
            do0(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd);
        end

        // Latency variants and back-to-back spacing.
        xact(1, 1'b0, 32'h0200_4000, 32'd0, 4'd0, rd, lat);
        check("latency_lat0", lat, 1);
        check("lat0_rdata", rd, 32'hFFFF_FFFF);
        spacing(1, 2);
        xact(2, 1'b1, 32'h0200_4000, 32'd5, 4'hF, rd, lat);
        check("latency_lat3", lat, 4);
        xact(2, 1'b0, 32'h0200_4000, 32'd0, 4'd0, rd, lat);
        check("lat3_rdata", rd, 32'd5);
        xact(2, 1'b1, 32'h0200_4000, 32'hFFFF_FFFF, 4'hF, rd, lat);
        spacing(2, 5);

        // Reset while BUSY: no response, registers back at reset values.
        xact(2, 1'b1, 32'h0200_4000, 32'd7, 4'hF, rd, lat);
        @(negedge clk);
        op_a[2] = 2'b01;
        addr_a[2] = 32'h0200_4000;
        @(posedge clk);
        @(negedge clk);
        check("busy_no_resp", resp_a[2], 0);
        rst_n2 = 1'b0;
        @(negedge clk);
        op_a[2] = 2'b00;
        rst_n2 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_resp_after_reset", resp_a[2], 0);
        end
        check("reset_timer_irq_dut2", tirq_a[2], 0);
        xact(2, 1'b0, 32'h0200_4000, 32'd0, 4'd0, rd, lat);
        check("mtimecmp_lo_after_reset", rd, 32'hFFFF_FFFF);
        check("latency_after_reset", lat, 4);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24100029_clint.md
Name: ysyx_24100029_clint

Overview:
- Core-local interruptor and timer; the responder end of the CPU data bus for the 0x02xx_xxxx window.
- Owns a free-running 64-bit mtime counter, a 64-bit mtimecmp compare register and an msip bit.
- Answers read/write requests using the bus's opcode/size/wstrb/rdata/resp signalling.
- Drives the machine timer and software interrupt lines into the CSR unit.

Parameters:
- TICK_DIV, 1, core clock cycles per mtime increment (≥1).
- RESP_LAT, 1, BUSY cycles between request acceptance and resp (0..7).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- clint_addr  input  32  byte address; decode uses addr[15:2] only.
- clint_opcode  input  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- clint_size  input  3  access size (0 byte, 1 half, 2 word); informational; writes governed by wstrb.
- clint_wdata  input  32  write data, lane-aligned.
- clint_wstrb  input  4  byte enables for writes.
- clint_rdata  output  32  read data, valid while clint_resp=1.
- clint_resp  output  1  one-cycle completion pulse.
- timer_irq  output  1  mtime >= mtimecmp (unsigned 64-bit).
- soft_irq  output  1  msip[0].

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, state=IDLE.
- Reset values (outputs): clint_resp=0, clint_rdata=0, timer_irq=0, soft_irq=0.
- Register map (offset addr[15:0]):
  - 0x0000 msip: bit0 R/W, other bits read 0.
  - 0x4000 mtimecmp[31:0].
  - 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0].
  - 0xBFFC mtime[63:32].
  - Other offsets: read 0, write ignored, still respond.
- Prescaler: counts 0..TICK_DIV-1; mtime increments by 1 when prescaler wraps to 0. With TICK_DIV=1, mtime increments every cycle. mtime wraps 2^64-1 -> 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: opcode 01/10 sampled at posedge = acceptance.
  - Write: applied at the acceptance edge using wstrb per byte.
  - Read: selected register value captured into an rdata hold register at the acceptance edge (pre-update value).
  - Next state: BUSY with latency counter=RESP_LAT, or RESP directly if RESP_LAT=0.
- BUSY: counter decrements each cycle; goes to RESP when the counter reaches 1. The bus holds its request; inputs are ignored.
- RESP: clint_resp=1 for exactly one cycle; clint_rdata=hold register (0 for writes); then returns to IDLE.
- clint_rdata=0 whenever clint_resp=0.
- Master handshake: the master drops or changes opcode in the cycle after resp. Any non-idle opcode seen in IDLE is a new request, so back-to-back requests have a one-cycle IDLE gap.
- Simultaneous tick and mtime write: written bytes take wdata; unwritten bytes take the incremented value, including carry across the 32-bit halves.
- timer_irq and soft_irq are registered: each reflects the compare result / msip of the previous cycle's register values (one-cycle lag).
- timer_irq after mtimecmp write: it updates the cycle after the new mtimecmp is visible; no glitch is allowed while one half of mtimecmp is being rewritten.
- Reset asserted mid-transaction: FSM goes to IDLE immediately and no resp is issued; the master must re-issue the request.
- Reserved opcode 11 in IDLE: no acceptance, no state change.

Test Plan:
- Reset then idle 10 cycles with TICK_DIV=1 -> read 0xBFF8 returns 10 plus the acceptance cycle offset (exact value checked against a model); resp arrives RESP_LAT+1 cycles after acceptance; timer_irq=0.
- Write mtimecmp lo=0x20 and hi=0 -> timer_irq rises the cycle after mtime reaches 0x20; writing hi=1 -> timer_irq drops within 2 cycles.
- Write msip with wdata=1, wstrb=4'b0001 -> soft_irq=1; write with wstrb=0 -> no change; read 0x0000 returns 0x1.
- Set mtime lo=0xFFFF_FFFF with TICK_DIV=1 -> next tick gives hi incremented, lo=0; a byte write (wstrb=4'b0010, wdata=0x0000_AB00) in a tick cycle merges lane 1 = 0xAB with the incremented value.
- Read 0x1234 and write 0x8000 -> rdata=0, resp pulses once, no register changes.
- RESP_LAT=0 and RESP_LAT=3 with back-to-back reads -> resp spacing 2 and 5 cycles respectively; reset pulled low in BUSY -> no resp, state IDLE, registers at reset values.
